// File: rtl/prv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prv32_pkg
// Description : Shared constants and types for the RV32I pipeline: datapath
//               width, ALU function codes and forward-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package prv32_pkg;

  localparam int XLEN = 32;

  // ALU function codes consumed by prv32_ALU
  localparam logic [3:0] ALUFN_ADD  = 4'b0000;
  localparam logic [3:0] ALUFN_SUB  = 4'b0001;
  localparam logic [3:0] ALUFN_SLL  = 4'b0010;
  localparam logic [3:0] ALUFN_SLT  = 4'b0011;
  localparam logic [3:0] ALUFN_SLTU = 4'b0100;
  localparam logic [3:0] ALUFN_XOR  = 4'b0101;
  localparam logic [3:0] ALUFN_SRL  = 4'b0110;
  localparam logic [3:0] ALUFN_SRA  = 4'b0111;
  localparam logic [3:0] ALUFN_OR   = 4'b1000;
  localparam logic [3:0] ALUFN_AND  = 4'b1001;
  localparam logic [3:0] ALUFN_PASS = 4'b1010;

  // Operand source select produced by the forwarding unit
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/prv32_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : prv32_fwd_unit
// Description : Combinational forward-source selector for one EX operand.
//               EX/MEM has priority over MEM/WB; x0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module prv32_fwd_unit
  import prv32_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic            exmem_regwrite,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            memwb_regwrite,
  input  logic [RA_W-1:0] memwb_rd,
  output fwd_sel_e        sel
);

  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_mem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src);
  assign w_hit_wb  = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src);

  // Pick the youngest producer that writes this source register
  always_comb begin
    sel = FWD_RF;
    if (w_hit_mem) begin
      sel = FWD_MEM;
    end else if (w_hit_wb) begin
      sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prv32_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : prv32_id_ex_stage
// Description : ID/EX pipeline register with EX-side operand forwarding,
//               ALU operand muxing and load-use stall / bubble insertion.
// Revision    : 1.0 - initial release
// ============================================================================
module prv32_id_ex_stage #(
  parameter int XLEN   = prv32_pkg::XLEN,
  parameter int RA_W   = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alufn,
  input  logic            id_asel,
  input  logic            id_bsel,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            hold,
  input  logic            flush,
  input  logic            exmem_regwrite,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            lu_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_shamt,
  output logic [3:0]      ex_alufn,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg
);

  import prv32_pkg::*;

  // EX-stage registers
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [RA_W-1:0] r_rd;
  logic [3:0]      r_alufn;
  logic            r_asel;
  logic            r_bsel;
  logic            r_regwrite;
  logic            r_memread;
  logic            r_memwrite;
  logic            r_memtoreg;

  logic            w_lu_stall;
  logic            w_bubble;
  fwd_sel_e        w_sel_rs1;
  fwd_sel_e        w_sel_rs2;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;

  // A load in EX whose destination is read by the instruction in ID cannot be
  // forwarded in time; once the bubble is loaded EX is invalid, so the stall
  // naturally lasts one cycle (longer only while hold freezes the load in EX).
  assign w_lu_stall = r_valid && r_memread && (r_rd != '0) && id_valid &&
                      ((r_rd == id_rs1) || (r_rd == id_rs2));
  assign lu_stall   = w_lu_stall;
  assign w_bubble   = flush || w_lu_stall;

  // EX register update: hold > flush > load-use bubble > capture from ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_alufn    <= '0;
      r_asel     <= 1'b0;
      r_bsel     <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else if (!hold) begin
      if (w_bubble) begin
        r_valid    <= 1'b0;
        r_pc       <= '0;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_rs1      <= '0;
        r_rs2      <= '0;
        r_rd       <= '0;
        r_alufn    <= '0;
        r_asel     <= 1'b0;
        r_bsel     <= 1'b0;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_memwrite <= 1'b0;
        r_memtoreg <= 1'b0;
      end else begin
        r_valid    <= id_valid;
        r_pc       <= id_pc;
        r_rs1_data <= id_rs1_data;
        r_rs2_data <= id_rs2_data;
        r_imm      <= id_imm;
        r_rs1      <= id_rs1;
        r_rs2      <= id_rs2;
        r_rd       <= id_rd;
        r_alufn    <= id_alufn;
        r_asel     <= id_asel;
        r_bsel     <= id_bsel;
        r_regwrite <= id_regwrite;
        r_memread  <= id_memread;
        r_memwrite <= id_memwrite;
        r_memtoreg <= id_memtoreg;
      end
    end
  end

  generate
    if (FWD_EN) begin : g_fwd_on
      prv32_fwd_unit #(.RA_W(RA_W)) u_fwd_rs1 (
        .src            (r_rs1),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .sel            (w_sel_rs1)
      );

      prv32_fwd_unit #(.RA_W(RA_W)) u_fwd_rs2 (
        .src            (r_rs2),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .sel            (w_sel_rs2)
      );
    end else begin : g_fwd_off
      // Debug build: operands always come from the register file read
      assign w_sel_rs1 = FWD_RF;
      assign w_sel_rs2 = FWD_RF;
    end
  endgenerate

  // Resolve each source operand from its selected producer
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    w_fwd_rs2 = r_rs2_data;
    case (w_sel_rs1)
      FWD_MEM: w_fwd_rs1 = exmem_result;
      FWD_WB:  w_fwd_rs1 = memwb_result;
      default: w_fwd_rs1 = r_rs1_data;
    endcase
    case (w_sel_rs2)
      FWD_MEM: w_fwd_rs2 = exmem_result;
      FWD_WB:  w_fwd_rs2 = memwb_result;
      default: w_fwd_rs2 = r_rs2_data;
    endcase
  end

  // ALU operand muxing: A is rs1 or PC, B is rs2 or immediate
  always_comb begin
    w_a = r_asel ? r_pc  : w_fwd_rs1;
    w_b = r_bsel ? r_imm : w_fwd_rs2;
  end

  assign ex_a          = w_a;
  assign ex_b          = w_b;
  assign ex_shamt      = w_b[4:0];
  assign ex_store_data = w_fwd_rs2;
  assign ex_valid      = r_valid;
  assign ex_alufn      = r_alufn;
  assign ex_pc         = r_pc;
  assign ex_rd         = r_rd;
  assign ex_regwrite   = r_regwrite;
  assign ex_memread    = r_memread;
  assign ex_memwrite   = r_memwrite;
  assign ex_memtoreg   = r_memtoreg;

endmodule
`default_nettype wire

// File: tb/tb_prv32_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_prv32_id_ex_stage
// Description : Self-checking bench for prv32_id_ex_stage. A behavioural model
//               of the EX slot is compared every cycle; directed literal checks
//               pin forwarding, load-use, flush/hold, muxing and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prv32_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  fn;
    logic        asel;
    logic        bsel;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mtr;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  rec_t id;
  rec_t m;
  logic hold, flush;
  logic exmem_regwrite, memwb_regwrite;
  logic [4:0] exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;

  logic        lu_stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [4:0]  ex_shamt, ex_rd;
  logic [3:0]  ex_alufn;

  logic        nf_lu_stall, nf_valid, nf_regwrite, nf_memread, nf_memwrite, nf_memtoreg;
  logic [31:0] nf_a, nf_b, nf_store_data, nf_pc;
  logic [4:0]  nf_shamt, nf_rd;
  logic [3:0]  nf_alufn;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prv32_id_ex_stage #(.XLEN(32), .RA_W(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id.valid), .id_pc(id.pc),
    .id_rs1_data(id.rs1d), .id_rs2_data(id.rs2d), .id_imm(id.imm),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_alufn(id.fn),
    .id_asel(id.asel), .id_bsel(id.bsel), .id_regwrite(id.rw),
    .id_memread(id.mr), .id_memwrite(id.mw), .id_memtoreg(id.mtr),
    .hold(hold), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .lu_stall(lu_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_shamt(ex_shamt), .ex_alufn(ex_alufn), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  prv32_id_ex_stage #(.XLEN(32), .RA_W(5), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .id_valid(id.valid), .id_pc(id.pc),
    .id_rs1_data(id.rs1d), .id_rs2_data(id.rs2d), .id_imm(id.imm),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_alufn(id.fn),
    .id_asel(id.asel), .id_bsel(id.bsel), .id_regwrite(id.rw),
    .id_memread(id.mr), .id_memwrite(id.mw), .id_memtoreg(id.mtr),
    .hold(hold), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .lu_stall(nf_lu_stall), .ex_valid(nf_valid), .ex_a(nf_a), .ex_b(nf_b),
    .ex_shamt(nf_shamt), .ex_alufn(nf_alufn), .ex_store_data(nf_store_data),
    .ex_pc(nf_pc), .ex_rd(nf_rd), .ex_regwrite(nf_regwrite),
    .ex_memread(nf_memread), .ex_memwrite(nf_memwrite), .ex_memtoreg(nf_memtoreg)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Value a source register must have in EX, given the producers in flight
  function automatic logic [31:0] src_val(input logic [4:0] src, input logic [31:0] rf, input bit en);
    if (!en || src == 5'd0) return rf;
    if (exmem_regwrite && exmem_rd == src) return exmem_result;
    if (memwb_regwrite && memwb_rd == src) return memwb_result;
    return rf;
  endfunction

  function automatic bit model_stall();
    return m.valid && m.mr && (m.rd != 5'd0) && id.valid &&
           ((m.rd == id.rs1) || (m.rd == id.rs2));
  endfunction

  // Model of the instruction occupying EX
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        m = '0;
    else if (hold)                     m = m;
    else if (flush || model_stall())   m = '0;
    else                               m = id;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] e_rs2, e_b;
    e_rs2 = src_val(m.rs2, m.rs2d, 1'b1);
    e_b   = m.bsel ? m.imm : e_rs2;
    chk("m_lu_stall", lu_stall, model_stall());
    chk("m_valid",    ex_valid, m.valid);
    chk("m_a",        ex_a, m.asel ? m.pc : src_val(m.rs1, m.rs1d, 1'b1));
    chk("m_b",        ex_b, e_b);
    chk("m_shamt",    ex_shamt, e_b[4:0]);
    chk("m_store",    ex_store_data, e_rs2);
    chk("m_pc",       ex_pc, m.pc);
    chk("m_rd",       ex_rd, m.rd);
    chk("m_alufn",    ex_alufn, m.fn);
    chk("m_ctrl",     {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                      {m.rw, m.mr, m.mw, m.mtr});
    chk("m_nf_a",     nf_a, m.asel ? m.pc : m.rs1d);
    chk("m_nf_b",     nf_b, m.bsel ? m.imm : m.rs2d);
    chk("m_nf_store", nf_store_data, m.rs2d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic new_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] rs1d,
                           input logic [4:0] rs2, input logic [31:0] rs2d, input logic [4:0] rd);
    id = '0;
    id.valid = 1'b1; id.pc = pc;
    id.rs1 = rs1; id.rs1d = rs1d; id.rs2 = rs2; id.rs2d = rs2d; id.rd = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; id = '0; hold = 1'b0; flush = 1'b0;
    clr_fwd();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ex_valid, 32'd0);
    chk("rst_alufn", ex_alufn, 32'd0);
    rst_n = 1'b1;

    // EX/MEM forward onto rs1
    new_instr(32'h40, 5'd5, 32'h1234, 5'd6, 32'h10, 5'd8);
    id.rw = 1'b1; id.fn = 4'b0000;
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAA;
    #1;
    chk("fwd_exmem_a", ex_a, 32'hAA);
    chk("nofwd_a", nf_a, 32'h1234);

    // EX/MEM beats MEM/WB on rs2
    new_instr(32'h44, 5'd1, 32'h5, 5'd7, 32'h77, 5'd9);
    id.rw = 1'b1;
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd7; memwb_result = 32'h22;
    #1;
    chk("fwd_prio_b", ex_b, 32'h11);
    chk("fwd_prio_store", ex_store_data, 32'h11);
    chk("nofwd_b", nf_b, 32'h77);
    exmem_regwrite = 1'b0;
    #1;
    chk("fwd_wb_b", ex_b, 32'h22);

    // x0 is never forwarded even with regwrite set
    new_instr(32'h48, 5'd2, 32'h3, 5'd0, 32'h55, 5'd10);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h22;
    #1;
    chk("x0_nofwd", ex_b, 32'h55);

    // Load-use: LW x3 then ADD reading x3
    clr_fwd();
    new_instr(32'h4C, 5'd1, 32'h1000, 5'd0, 32'h0, 5'd3);
    id.imm = 32'h4; id.bsel = 1'b1; id.rw = 1'b1; id.mr = 1'b1; id.mtr = 1'b1;
    tick();
    new_instr(32'h50, 5'd3, 32'h9999, 5'd2, 32'h7, 5'd4);
    id.rw = 1'b1;
    #1;
    chk("lu_stall_on", lu_stall, 32'd1);
    tick();
    chk("lu_bubble_valid", ex_valid, 32'd0);
    chk("lu_stall_off", lu_stall, 32'd0);
    tick();
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hDEAD0003;
    #1;
    chk("lu_wb_fwd", ex_a, 32'hDEAD0003);
    chk("lu_add_pc", ex_pc, 32'h50);

    // Load-use while held: stall persists, still only one bubble
    clr_fwd();
    new_instr(32'h54, 5'd1, 32'h2000, 5'd0, 32'h0, 5'd3);
    id.rw = 1'b1; id.mr = 1'b1; id.mtr = 1'b1;
    tick();
    new_instr(32'h58, 5'd0, 32'h0, 5'd3, 32'h8, 5'd6);
    id.rw = 1'b1;
    hold = 1'b1;
    #1;
    chk("lu_hold_stall0", lu_stall, 32'd1);
    tick();
    chk("lu_hold_stall1", lu_stall, 32'd1);
    chk("lu_hold_pc", ex_pc, 32'h54);
    hold = 1'b0;
    tick();
    chk("lu_hold_bubble", ex_valid, 32'd0);
    tick();
    chk("lu_hold_next_pc", ex_pc, 32'h58);
    chk("lu_hold_next_valid", ex_valid, 32'd1);

    // Flush loads a bubble; flush under hold is dropped
    new_instr(32'h60, 5'd2, 32'h1, 5'd5, 32'h2, 5'd0);
    id.mw = 1'b1; id.bsel = 1'b1; id.imm = 32'h8;
    flush = 1'b1;
    tick();
    chk("flush_valid", ex_valid, 32'd0);
    chk("flush_memwrite", ex_memwrite, 32'd0);
    flush = 1'b0;
    new_instr(32'h64, 5'd1, 32'h4, 5'd2, 32'h5, 5'd10);
    id.rw = 1'b1;
    tick();
    new_instr(32'h68, 5'd1, 32'h4, 5'd2, 32'h5, 5'd0);
    id.mw = 1'b1;
    flush = 1'b1; hold = 1'b1;
    tick();
    chk("fh_pc", ex_pc, 32'h64);
    chk("fh_valid", ex_valid, 32'd1);
    chk("fh_regwrite", ex_regwrite, 32'd1);
    flush = 1'b0; hold = 1'b0;

    // AUIPC-style muxing and shift amount
    new_instr(32'h100, 5'd1, 32'h5, 5'd2, 32'h6, 5'd11);
    id.asel = 1'b1; id.bsel = 1'b1; id.imm = 32'h2000; id.rw = 1'b1;
    tick();
    chk("auipc_a", ex_a, 32'h100);
    chk("auipc_b", ex_b, 32'h2000);
    new_instr(32'h104, 5'd11, 32'h3, 5'd0, 32'h0, 5'd12);
    id.bsel = 1'b1; id.imm = 32'h1F; id.fn = 4'b0010; id.rw = 1'b1;
    tick();
    chk("shamt", ex_shamt, 32'd31);
    chk("shamt_alufn", ex_alufn, 32'h2);

    // Asynchronous reset mid-stream
    new_instr(32'h200, 5'd4, 32'h33, 5'd0, 32'h0, 5'd13);
    id.rw = 1'b1;
    tick();
    chk("pre_rst_a", ex_a, 32'h33);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ex_valid, 32'd0);
    chk("arst_regwrite", ex_regwrite, 32'd0);
    chk("arst_lu_stall", lu_stall, 32'd0);
    chk("arst_a", ex_a, 32'd0);
    tick();
    chk("arst_a_held", ex_a, 32'd0);
    rst_n = 1'b1;
    id = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
